// File: rtl/tlb_translator.sv
// tlb_translator
// MIPS virtual-to-physical address translator sitting between the pipeline
// address stage and the I/D cache request ports. kseg0/kseg1 are mapped
// directly; useg and kseg2/kseg3 go through a fully-associative dual-page TLB.
// The lookup is registered (latency 1) with a valid/ready handshake on both
// request and response sides, and TLB exceptions are reported with the result.
//
// Ports
//   clk, resetn                    clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_vaddr, req_is_store,       virtual address, store flag, current ASID
//   req_asid
//   resp_valid/resp_ready          response handshake
//   resp_paddr, resp_uncached,     physical address, cache bypass,
//   resp_exc                       exception (00 none, 01 refill, 10 invalid,
//                                  11 modified)
//   tlb_we, tlb_widx, tlb_wvpn2,   TLB entry write port
//   tlb_wasid, tlb_wg, tlb_wlo0,
//   tlb_wlo1
//   tlb_flush                      invalidate every entry
module tlb_translator #(
    parameter int TLB_ENTRIES = 8,
    parameter int ASID_W      = 8,
    parameter bit K0_CACHED   = 1'b1,
    localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_vaddr,
    input  logic              req_is_store,
    input  logic [ASID_W-1:0] req_asid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_paddr,
    output logic              resp_uncached,
    output logic [1:0]        resp_exc,
    input  logic              tlb_we,
    input  logic [IDX_W-1:0]  tlb_widx,
    input  logic [18:0]       tlb_wvpn2,
    input  logic [ASID_W-1:0] tlb_wasid,
    input  logic              tlb_wg,
    input  logic [22:0]       tlb_wlo0,
    input  logic [22:0]       tlb_wlo1,
    input  logic              tlb_flush
);

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_REFILL  = 2'b01;
    localparam logic [1:0] EXC_INVALID = 2'b10;
    localparam logic [1:0] EXC_MOD     = 2'b11;

    logic [TLB_ENTRIES-1:0] present;
    logic [18:0]            vpn2_q [TLB_ENTRIES];
    logic [ASID_W-1:0]      asid_q [TLB_ENTRIES];
    logic                   g_q    [TLB_ENTRIES];
    logic [22:0]            lo0_q  [TLB_ENTRIES];
    logic [22:0]            lo1_q  [TLB_ENTRIES];

    logic [TLB_ENTRIES-1:0] match;
    logic                   hit;
    logic [22:0]            sel_lo;
    logic                   accept;
    logic [31:0]            nxt_paddr;
    logic                   nxt_uncached;
    logic [1:0]             nxt_exc;

    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        match = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            match[i] = present[i] && (vpn2_q[i] == req_vaddr[31:13]) &&
                       (g_q[i] || (asid_q[i] == req_asid));
        end
    end

    // Scan from the top down so the lowest matching index is the one left.
    always_comb begin
        hit    = 1'b0;
        sel_lo = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit    = 1'b1;
                sel_lo = req_vaddr[12] ? lo1_q[i] : lo0_q[i];
            end
        end
    end

    // sel_lo layout: [22:3] pfn, [2] uncached, [1] dirty, [0] valid
    always_comb begin
        nxt_paddr    = '0;
        nxt_uncached = 1'b0;
        nxt_exc      = EXC_NONE;
        if (req_vaddr[31:30] == 2'b10) begin
            nxt_paddr    = {3'b000, req_vaddr[28:0]};
            nxt_uncached = req_vaddr[29] ? 1'b1 : !K0_CACHED;
        end else if (!hit) begin
            nxt_exc = EXC_REFILL;
        end else if (!sel_lo[0]) begin
            nxt_exc = EXC_INVALID;
        end else if (req_is_store && !sel_lo[1]) begin
            nxt_exc = EXC_MOD;
        end else begin
            nxt_paddr    = {sel_lo[22:3], req_vaddr[11:0]};
            nxt_uncached = sel_lo[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid    <= 1'b0;
            resp_paddr    <= '0;
            resp_uncached <= 1'b0;
            resp_exc      <= EXC_NONE;
            present       <= '0;
        end else begin
            if (accept) begin
                resp_valid    <= 1'b1;
                resp_paddr    <= nxt_paddr;
                resp_uncached <= nxt_uncached;
                resp_exc      <= nxt_exc;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            // The write is ordered after the flush so a simultaneous write survives.
            if (tlb_flush) present <= '0;
            if (tlb_we) present[tlb_widx] <= 1'b1;
        end
    end

    // Entry payload needs no reset: it is only observed through a present bit.
    always_ff @(posedge clk) begin
        if (tlb_we) begin
            vpn2_q[tlb_widx] <= tlb_wvpn2;
            asid_q[tlb_widx] <= tlb_wasid;
            g_q[tlb_widx]    <= tlb_wg;
            lo0_q[tlb_widx]  <= tlb_wlo0;
            lo1_q[tlb_widx]  <= tlb_wlo1;
        end
    end

endmodule

// File: tb/tb_tlb_translator.sv
// Testbench for tlb_translator: directed steps followed by random traffic,
// all checked against a behavioural translation model.
module tb_tlb_translator;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_is_store;
    logic [7:0]  req_asid;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_paddr;
    logic        resp_uncached;
    logic [1:0]  resp_exc;
    logic        tlb_we;
    logic [2:0]  tlb_widx;
    logic [18:0] tlb_wvpn2;
    logic [7:0]  tlb_wasid;
    logic        tlb_wg;
    logic [22:0] tlb_wlo0;
    logic [22:0] tlb_wlo1;
    logic        tlb_flush;

    tlb_translator dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_is_store(req_is_store), .req_asid(req_asid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_uncached(resp_uncached), .resp_exc(resp_exc),
        .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wvpn2(tlb_wvpn2),
        .tlb_wasid(tlb_wasid), .tlb_wg(tlb_wg), .tlb_wlo0(tlb_wlo0),
        .tlb_wlo1(tlb_wlo1), .tlb_flush(tlb_flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_present [8];
    logic [18:0] m_vpn     [8];
    logic [7:0]  m_asid    [8];
    logic        m_g       [8];
    logic [22:0] m_lo0     [8];
    logic [22:0] m_lo1     [8];
    bit          exp_valid;
    bit          exp_known;
    logic [31:0] exp_paddr;
    logic        exp_unc;
    logic [1:0]  exp_exc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Translation computed straight from the address-map rules.
    task automatic model_lookup(input logic [31:0] va, input logic st, input logic [7:0] as,
                                output logic [31:0] pa, output logic unc, output logic [1:0] exc);
        int          hit_idx;
        logic [22:0] lo;
        pa = 32'h0; unc = 1'b0; exc = 2'd0;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
            pa = va - 32'h8000_0000;
            unc = 1'b0;
        end else if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
            pa = va - 32'hA000_0000;
            unc = 1'b1;
        end else begin
            hit_idx = -1;
            for (int i = 7; i >= 0; i--)
                if (m_present[i] && m_vpn[i] == va / 32'h2000 && (m_g[i] || m_asid[i] == as))
                    hit_idx = i;
            if (hit_idx < 0) exc = 2'd1;
            else begin
                lo = ((va / 32'h1000) % 2 == 1) ? m_lo1[hit_idx] : m_lo0[hit_idx];
                if (lo[0] == 1'b0) exc = 2'd2;
                else if (st && lo[1] == 1'b0) exc = 2'd3;
                else begin
                    pa  = {12'h0, lo[22:3]} * 32'h1000 + va % 32'h1000;
                    unc = lo[2];
                end
            end
        end
    endtask

    task automatic cycle();
        bit          acc;
        bit          exp_ready;
        logic [31:0] pa;
        logic        u;
        logic [1:0]  e;
        #1;
        exp_ready = !exp_valid || resp_ready;
        check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        acc = req_valid && exp_ready;
        if (acc) model_lookup(req_vaddr, req_is_store, req_asid, pa, u, e);
        @(posedge clk);
        if (!resetn) begin
            exp_valid = 0; exp_known = 1; exp_paddr = 0; exp_unc = 0; exp_exc = 0;
            for (int i = 0; i < 8; i++) m_present[i] = 0;
        end else begin
            if (acc) begin
                exp_valid = 1; exp_known = 1; exp_paddr = pa; exp_unc = u; exp_exc = e;
            end else if (resp_ready) begin
                exp_valid = 0; exp_known = 0;
            end
            if (tlb_flush) for (int i = 0; i < 8; i++) m_present[i] = 0;
            if (tlb_we) begin
                m_present[tlb_widx] = 1; m_vpn[tlb_widx] = tlb_wvpn2;
                m_asid[tlb_widx] = tlb_wasid; m_g[tlb_widx] = tlb_wg;
                m_lo0[tlb_widx] = tlb_wlo0; m_lo1[tlb_widx] = tlb_wlo1;
            end
        end
        #1;
        check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
        if (exp_known) begin
            check("resp_paddr", resp_paddr, exp_paddr);
            check("resp_uncached", {31'b0, resp_uncached}, {31'b0, exp_unc});
            check("resp_exc", {30'b0, resp_exc}, {30'b0, exp_exc});
        end
    endtask

    task automatic req(input logic [31:0] va, input logic st, input logic [7:0] as);
        req_valid = 1; req_vaddr = va; req_is_store = st; req_asid = as;
    endtask

    task automatic idle();
        req_valid = 0; tlb_we = 0; tlb_flush = 0;
    endtask

    task automatic tlb_write(input int idx, input logic [18:0] vpn, input logic [7:0] as,
                             input logic g, input logic [22:0] l0, input logic [22:0] l1);
        tlb_we = 1; tlb_widx = idx[2:0]; tlb_wvpn2 = vpn; tlb_wasid = as;
        tlb_wg = g; tlb_wlo0 = l0; tlb_wlo1 = l1;
    endtask

    logic [18:0] vpn_pool [6];
    logic [31:0] rnd;

    initial begin
        vpn_pool[0] = 19'h00200; vpn_pool[1] = 19'h00300; vpn_pool[2] = 19'h60000;
        vpn_pool[3] = 19'h7FFFF; vpn_pool[4] = 19'h40000; vpn_pool[5] = 19'h5FE00;
        exp_valid = 0; exp_known = 0; exp_paddr = 0; exp_unc = 0; exp_exc = 0;
        for (int i = 0; i < 8; i++) m_present[i] = 0;
        resetn = 0; resp_ready = 1; req_vaddr = 0; req_is_store = 0; req_asid = 0;
        tlb_widx = 0; tlb_wvpn2 = 0; tlb_wasid = 0; tlb_wg = 0; tlb_wlo0 = 0; tlb_wlo1 = 0;
        idle();
        cycle(); cycle();
        check("reset resp_valid", {31'b0, resp_valid}, 32'h0);
        check("reset resp_paddr", resp_paddr, 32'h0);
        resetn = 1;

        // Unmapped regions
        req(32'hBFC0_0000, 0, 8'd5); cycle();
        check("kseg1 paddr", resp_paddr, 32'h1FC0_0000);
        check("kseg1 uncached", {31'b0, resp_uncached}, 32'h1);
        req(32'h8000_1234, 0, 8'd5); cycle();
        check("kseg0 paddr", resp_paddr, 32'h0000_1234);
        check("kseg0 uncached", {31'b0, resp_uncached}, 32'h0);

        // Empty TLB
        req(32'h0040_1000, 0, 8'd5); cycle();
        check("empty useg exc", {30'b0, resp_exc}, 32'h1);
        req(32'hC000_0000, 0, 8'd5); cycle();
        check("empty kseg2 exc", {30'b0, resp_exc}, 32'h1);

        // Mapped hits and exceptions
        idle();
        tlb_write(3, 19'h00200, 8'd5, 0, {20'h12345, 3'b001}, {20'h54321, 3'b111});
        cycle(); idle();
        req(32'h0040_0ABC, 0, 8'd5); cycle();
        check("hit lo0 paddr", resp_paddr, 32'h1234_5ABC);
        req(32'h0040_0ABC, 1, 8'd5); cycle();
        check("store mod exc", {30'b0, resp_exc}, 32'h3);
        req(32'h0040_1ABC, 0, 8'd5); cycle();
        check("hit lo1 paddr", resp_paddr, 32'h5432_1ABC);
        check("hit lo1 uncached", {31'b0, resp_uncached}, 32'h1);
        req(32'h0040_0ABC, 0, 8'd6); cycle();
        check("asid miss exc", {30'b0, resp_exc}, 32'h1);

        // Backpressure
        req(32'h0040_0ABC, 0, 8'd5); cycle();
        resp_ready = 0; req(32'h0040_1ABC, 0, 8'd5);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall req_ready", {31'b0, req_ready}, 32'h0);
            check("stall paddr", resp_paddr, 32'h1234_5ABC);
        end
        resp_ready = 1; cycle();
        check("release paddr", resp_paddr, 32'h5432_1ABC);
        req(32'h8000_0010, 0, 8'd5); cycle();
        req(32'hA000_0020, 0, 8'd5); cycle();
        req(32'h0040_0004, 0, 8'd5); cycle();
        check("b2b paddr", resp_paddr, 32'h1234_5004);

        // Write/flush ordering
        req(32'h0060_0010, 0, 8'd5);
        tlb_write(0, 19'h00300, 8'd9, 1, {20'hAAAAA, 3'b011}, 23'h0);
        cycle(); tlb_we = 0;
        check("write same cycle exc", {30'b0, resp_exc}, 32'h1);
        cycle();
        check("write repeat paddr", resp_paddr, 32'hAAAA_A010);
        idle(); tlb_flush = 1; cycle(); tlb_flush = 0;
        req(32'h0060_0010, 0, 8'd5); cycle();
        check("flush exc", {30'b0, resp_exc}, 32'h1);

        // Reset during a stalled response
        idle();
        tlb_write(3, 19'h00200, 8'd5, 0, {20'h12345, 3'b001}, {20'h54321, 3'b111});
        cycle(); idle();
        req(32'h0040_0ABC, 0, 8'd5); cycle();
        idle(); resp_ready = 0; cycle();
        resetn = 0; cycle(); resetn = 1; resp_ready = 1;
        check("reset stall valid", {31'b0, resp_valid}, 32'h0);
        req(32'h0040_0ABC, 0, 8'd5); cycle();
        check("reset tlb empty", {30'b0, resp_exc}, 32'h1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            idle();
            rnd = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                req({vpn_pool[$urandom_range(0, 5)], rnd[12:0]}, rnd[13], 8'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0)
                tlb_write($urandom_range(0, 7), vpn_pool[$urandom_range(0, 3)],
                          8'($urandom_range(0, 3)), rnd[14],
                          {rnd[31:12], rnd[16:15], ($urandom_range(0, 3) != 0)},
                          {rnd[27:8], rnd[18:17], ($urandom_range(0, 3) != 0)});
            tlb_flush = ($urandom_range(0, 60) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
